// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks a one-cycle-latency program ROM and presents
// one- or two-word instructions to the decoder. Build with FETCH_LONG_INSN_EN to enable two-word detection.
module instr_fetch #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  instr_ready,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_word0,
  output logic [DATA_WIDTH-1:0] instr_word1,
  output logic                  instr_long,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [1:0]            fsm_state
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] FETCH2 = 2'd1;
  localparam logic [1:0] VALID  = 2'd2;

  // Handshake: an instruction transfers on a rising edge where instr_valid
  // and instr_ready are both 1; while instr_ready is 0 every instr_* output
  // holds. redirect_valid overrides everything and drops the presented word.

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] word0_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  is_long;

`ifdef FETCH_LONG_INSN_EN
  // LDS/STS and JMP/CALL carry a second program word.
  assign is_long = ((rom_data & DATA_WIDTH'(16'hFC0F)) == DATA_WIDTH'(16'h9000)) ||
                   ((rom_data & DATA_WIDTH'(16'hFE0C)) == DATA_WIDTH'(16'h940C));
`else
  assign is_long = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= '0;
      word0_q <= '0;
      pc_q    <= '0;
    end else if (redirect_valid) begin
      state <= FETCH;
      pc    <= redirect_pc;
    end else begin
      case (state)
        FETCH: begin
          word0_q <= rom_data;
          pc_q    <= pc;
          pc      <= pc + ADDR_WIDTH'(1);
          state   <= is_long ? FETCH2 : VALID;
        end
        FETCH2: begin
          pc    <= pc + ADDR_WIDTH'(1);
          state <= VALID;
        end
        VALID: begin
          if (instr_ready) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_LONG_INSN_EN
  logic [DATA_WIDTH-1:0] word1_q;
  logic                  long_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word1_q <= '0;
      long_q  <= 1'b0;
    end else if (!redirect_valid) begin
      if (state == FETCH) begin
        word1_q <= '0;
        long_q  <= is_long;
      end else if (state == FETCH2) begin
        word1_q <= rom_data;
      end
    end
  end

  assign instr_word1 = word1_q;
  assign instr_long  = long_q;
`else
  assign instr_word1 = '0;
  assign instr_long  = 1'b0;
`endif

  assign rom_addr    = pc;
  assign instr_valid = (state == VALID);
  assign instr_word0 = word0_q;
  assign instr_pc    = pc_q;
  assign fsm_state   = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: behavioural ROM, expected-instruction queue
// and field checks; expectations adapt to FETCH_LONG_INSN_EN.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [15:0] instr_word0;
  logic [15:0] instr_word1;
  logic        instr_long;
  logic [7:0]  instr_pc;
  logic [1:0]  fsm_state;

  logic [15:0] rom [256];
  logic [40:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  instr_fetch #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_ready    (instr_ready),
    .instr_valid    (instr_valid),
    .instr_word0    (instr_word0),
    .instr_word1    (instr_word1),
    .instr_long     (instr_long),
    .instr_pc       (instr_pc),
    .fsm_state      (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM answers on the falling edge for the address held that cycle
  always @(negedge clk) rom_data = rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_instr(input logic [7:0] pc, input logic [15:0] w0,
                              input logic [15:0] w1, input logic lng);
    exp_q.push_back({pc, w0, w1, lng});
  endtask

  // advance to the next presented instruction and compare it with the queue head
  task automatic next_instr(input string tag);
    int          n;
    logic [40:0] e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 40);
    e = exp_q.pop_front();
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_pc"},    32'(instr_pc),    32'(e[40:33]));
    check({tag, "_w0"},    32'(instr_word0), 32'(e[32:17]));
    check({tag, "_w1"},    32'(instr_word1), 32'(e[16:1]));
    check({tag, "_long"},  32'(instr_long),  32'(e[0]));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'hE0C3;
    rom[8'h01] = 16'hB9C6;
    rom[8'h02] = 16'h940C;
    rom[8'h03] = 16'h0010;
    rom[8'h04] = 16'h1111;
    rom[8'h05] = 16'h2222;
    rom[8'h06] = 16'h940E;
    rom[8'h07] = 16'h0050;
    rom[8'h10] = 16'h3333;
    rom[8'hFF] = 16'h9000;

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    instr_ready    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_w0",    32'(instr_word0), 32'd0);
    check("rst_w1",    32'(instr_word1), 32'd0);
    check("rst_long",  32'(instr_long),  32'd0);
    check("rst_pc",    32'(instr_pc),    32'd0);
    check("rst_addr",  32'(rom_addr),    32'd0);
    reset = 1'b0;

    // sequential short and long instructions
    expect_instr(8'h00, 16'hE0C3, 16'h0000, 1'b0);
    expect_instr(8'h01, 16'hB9C6, 16'h0000, 1'b0);
`ifdef FETCH_LONG_INSN_EN
    expect_instr(8'h02, 16'h940C, 16'h0010, 1'b1);
`else
    expect_instr(8'h02, 16'h940C, 16'h0000, 1'b0);
    expect_instr(8'h03, 16'h0010, 16'h0000, 1'b0);
`endif
    expect_instr(8'h04, 16'h1111, 16'h0000, 1'b0);
    next_instr("i0");
    next_instr("i1");
    next_instr("jmp");
`ifndef FETCH_LONG_INSN_EN
    next_instr("jmp_lo");
`endif
    next_instr("i4");

    // back-pressure: everything holds while ready is low
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_w0",    32'(instr_word0), 32'h1111);
      check("hold_w1",    32'(instr_word1), 32'h0000);
      check("hold_long",  32'(instr_long),  32'd0);
      check("hold_pc",    32'(instr_pc),    32'h04);
      check("hold_addr",  32'(rom_addr),    32'h05);
    end
    instr_ready = 1'b1;
    expect_instr(8'h05, 16'h2222, 16'h0000, 1'b0);
    next_instr("i5");

    // redirect while the CALL at 6 is mid-fetch
    @(negedge clk);
    @(negedge clk);
`ifdef FETCH_LONG_INSN_EN
    check("f2_state", 32'(fsm_state), 32'd1);
    check("f2_valid", 32'(instr_valid), 32'd0);
`else
    check("f2_valid", 32'(instr_valid), 32'd1);
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 8'h10;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("redir_valid", 32'(instr_valid), 32'd0);
    check("redir_addr",  32'(rom_addr),    32'h10);
    expect_instr(8'h10, 16'h3333, 16'h0000, 1'b0);
    next_instr("redir");

    // redirect together with consume, then long opcode at the top address
    rom[8'h00]     = 16'h1234;
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("both_valid", 32'(instr_valid), 32'd0);
    check("both_addr",  32'(rom_addr),    32'hFF);
`ifdef FETCH_LONG_INSN_EN
    expect_instr(8'hFF, 16'h9000, 16'h1234, 1'b1);
`else
    expect_instr(8'hFF, 16'h9000, 16'h0000, 1'b0);
    expect_instr(8'h00, 16'h1234, 16'h0000, 1'b0);
`endif
    expect_instr(8'h01, 16'hB9C6, 16'h0000, 1'b0);
    next_instr("wrap");
`ifndef FETCH_LONG_INSN_EN
    next_instr("wrap_lo");
`endif
    next_instr("after_wrap");

    // asynchronous reset while an instruction is presented
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_pc",    32'(instr_pc),    32'd0);
    check("arst_w0",    32'(instr_word0), 32'd0);
    check("arst_addr",  32'(rom_addr),    32'd0);
    @(negedge clk);
    reset = 1'b0;
    expect_instr(8'h00, 16'h1234, 16'h0000, 1'b0);
    next_instr("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
